// File: rtl/strip_conv3x3_engine.sv
// rtl/strip_conv3x3_engine.sv - 3x3 signed strip convolution engine with result RAM read-back
// Optional STRIP_CONV_RELU_EN clamps negative sums to zero before they are stored.
module strip_conv3x3_engine #(
    parameter int IMG_W = 224,
    parameter int IMG_H = 30,
    parameter int DW    = 9,
    parameter int OW    = 23
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic              kernel_read_complete_i,
    input  logic [9*DW-1:0]   kernel_i,
    output logic              fmap_en_o,
    output logic [15:0]       fmap_addr_o,
    input  logic [DW-1:0]     fmap_data_i,
    input  logic [12:0]       rd_addr_i,
    output logic [OW-1:0]     rd_data_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int OUT_W = IMG_W - 2;
    localparam int OUT_H = IMG_H - 2;
    localparam int N_OUT = OUT_W * OUT_H;
    localparam int AW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, MUL, ACC, NEXT, DONE} state_t;

    state_t                 state_q;
    logic [15:0]            r_q, c_q;
    logic [3:0]             j_q;
    logic                   fmap_en_q, busy_q, done_q;
    logic [15:0]            fmap_addr_q;
    logic signed [DW-1:0]   kern_q  [9];
    logic signed [DW-1:0]   patch_q [9];
    logic signed [2*DW-1:0] prod_q  [9];
    logic [OW-1:0]          rd_data_q;
    logic [OW-1:0]          ram [N_OUT];

    logic [15:0]            r_d, c_d;
    logic                   last_px;
    logic signed [OW-1:0]   acc_sum, wr_data;
    logic [AW-1:0]          wr_idx;

    // Address of tap j of the 3x3 window whose top-left pixel is (r, c).
    function automatic logic [15:0] tap_addr(input logic [15:0] r, input logic [15:0] c,
                                             input logic [3:0] j);
        int row, col;
        row = int'(j) / 3;
        col = int'(j) % 3;
        return 16'((int'(r) + row) * IMG_W + int'(c) + col);
    endfunction

    assign last_px = (r_q == 16'(OUT_H - 1)) && (c_q == 16'(OUT_W - 1));
    assign wr_idx  = AW'(32'(r_q) * 32'(OUT_W) + 32'(c_q));

    always_comb begin
        r_d = r_q;
        c_d = c_q + 16'd1;
        if (c_q == 16'(OUT_W - 1)) begin
            c_d = '0;
            r_d = r_q + 16'd1;
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int j = 0; j < 9; j++) begin
            acc_sum = acc_sum + OW'(prod_q[j]);
        end
`ifdef STRIP_CONV_RELU_EN
        wr_data = acc_sum[OW-1] ? '0 : acc_sum;
`else
        wr_data = acc_sum;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (state_q == ACC) begin
            ram[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_data_q <= '0;
        end else if (32'(rd_addr_i) < 32'(N_OUT)) begin
            rd_data_q <= ram[rd_addr_i[AW-1:0]];
        end else begin
            rd_data_q <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            r_q         <= '0;
            c_q         <= '0;
            j_q         <= '0;
            fmap_en_q   <= 1'b0;
            fmap_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int j = 0; j < 9; j++) begin
                kern_q[j]  <= '0;
                patch_q[j] <= '0;
                prod_q[j]  <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i && kernel_read_complete_i) begin
                        for (int j = 0; j < 9; j++) begin
                            kern_q[j] <= kernel_i[j*DW +: DW];
                        end
                        r_q         <= '0;
                        c_q         <= '0;
                        j_q         <= '0;
                        fmap_en_q   <= 1'b1;
                        fmap_addr_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
                    // Read data lags the request by one cycle, so tap j-1 lands now.
                    if (j_q != 4'd0) begin
                        patch_q[j_q - 4'd1] <= fmap_data_i;
                    end
                    if (j_q == 4'd8) begin
                        fmap_en_q <= 1'b0;
                        state_q   <= WAIT;
                    end else begin
                        j_q         <= j_q + 4'd1;
                        fmap_addr_q <= tap_addr(r_q, c_q, j_q + 4'd1);
                    end
                end
                WAIT: begin
                    patch_q[8] <= fmap_data_i;
                    state_q    <= MUL;
                end
                MUL: begin
                    for (int j = 0; j < 9; j++) begin
                        prod_q[j] <= patch_q[j] * kern_q[j];
                    end
                    state_q <= ACC;
                end
                ACC: begin
                    state_q <= NEXT;
                end
                NEXT: begin
                    if (last_px) begin
                        state_q <= DONE;
                    end else begin
                        r_q         <= r_d;
                        c_q         <= c_d;
                        j_q         <= '0;
                        fmap_en_q   <= 1'b1;
                        fmap_addr_q <= tap_addr(r_d, c_d, 4'd0);
                        state_q     <= FETCH;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    // done is always shown for at least one cycle before start may release it.
                    if (!start_i && done_q) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fmap_en_o   = fmap_en_q;
    assign fmap_addr_o = fmap_addr_q;
    assign rd_data_o   = rd_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_strip_conv3x3_engine.sv
// tb/tb_strip_conv3x3_engine.sv - self-checking bench for strip_conv3x3_engine (small and default strips)
module tb_strip_conv3x3_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        s_rst_n, s_start, s_kc, s_fmap_en, s_busy, s_done;
    logic [80:0] s_kernel;
    logic [15:0] s_fmap_addr;
    logic [8:0]  s_fmap_data;
    logic [12:0] s_rd_addr;
    logic [22:0] s_rd_data;

    logic        d_rst_n, d_start, d_kc, d_fmap_en, d_busy, d_done;
    logic [80:0] d_kernel;
    logic [15:0] d_fmap_addr;
    logic [8:0]  d_fmap_data;
    logic [12:0] d_rd_addr;
    logic [22:0] d_rd_data;

    logic [8:0]  mem_s [20];
    logic [8:0]  mem_d [6720];
    logic [22:0] sb_s [$];
    logic [22:0] sb_d [$];

    strip_conv3x3_engine #(.IMG_W(5), .IMG_H(4)) u_small (
        .clk_i(clk), .reset_ni(s_rst_n), .start_i(s_start), .kernel_read_complete_i(s_kc),
        .kernel_i(s_kernel), .fmap_en_o(s_fmap_en), .fmap_addr_o(s_fmap_addr),
        .fmap_data_i(s_fmap_data), .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data),
        .busy_o(s_busy), .done_o(s_done)
    );

    strip_conv3x3_engine u_dflt (
        .clk_i(clk), .reset_ni(d_rst_n), .start_i(d_start), .kernel_read_complete_i(d_kc),
        .kernel_i(d_kernel), .fmap_en_o(d_fmap_en), .fmap_addr_o(d_fmap_addr),
        .fmap_data_i(d_fmap_data), .rd_addr_i(d_rd_addr), .rd_data_o(d_rd_data),
        .busy_o(d_busy), .done_o(d_done)
    );

    always @(posedge clk) begin
        if (s_fmap_en) s_fmap_data <= mem_s[s_fmap_addr[4:0]];
        if (d_fmap_en) d_fmap_data <= mem_d[d_fmap_addr[12:0]];
    end

    function automatic logic [80:0] kfill(input int v);
        logic [80:0] k;
        for (int j = 0; j < 9; j++) k[j*9 +: 9] = 9'(v);
        return k;
    endfunction

    function automatic logic [80:0] krand();
        logic [80:0] k;
        for (int j = 0; j < 9; j++) k[j*9 +: 9] = 9'($urandom_range(0, 511));
        return k;
    endfunction

    function automatic logic [22:0] golden(input bit big, input int idx, input logic [80:0] k);
        int w, r, c, sum;
        logic [8:0] pv, kv;
        w = big ? 224 : 5;
        if (idx >= (big ? 6216 : 6)) return '0;
        r = idx / (w - 2);
        c = idx % (w - 2);
        sum = 0;
        for (int j = 0; j < 9; j++) begin
            pv = big ? mem_d[(r + j / 3) * w + c + j % 3] : mem_s[(r + j / 3) * w + c + j % 3];
            kv = k[j*9 +: 9];
            sum += int'($signed(pv)) * int'($signed(kv));
        end
`ifdef STRIP_CONV_RELU_EN
        if (sum < 0) sum = 0;
`endif
        return 23'(sum);
    endfunction

    task automatic start_s(input logic [80:0] k);
        @(negedge clk);
        s_kernel = k;
        s_start  = 1'b1;
        s_kc     = 1'b1;
        @(posedge clk);
        #1 s_kernel = krand();
    endtask

    task automatic wait_s(output int lat);
        lat = 0;
        while (lat < 300 && s_done !== 1'b1) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic release_s();
        @(negedge clk);
        s_start = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_busy, s_done, s_fmap_en} !== 3'b000 || s_fmap_addr !== 16'd0 || s_rd_data !== 23'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b en=%b addr=%0d rd=%0d required all 0",
                     s_busy, s_done, s_fmap_en, s_fmap_addr, s_rd_data);
        end
        @(negedge clk) s_rst_n = 1'b1;
    endtask

    task automatic test_kernel_gate_center();
        logic [80:0] k;
        logic [22:0] exp;
        logic [15:0] seq [4];
        int lat;
        bit saw_en, saw_busy;
        seq = '{16'd0, 16'd1, 16'd2, 16'd5};
        for (int a = 0; a < 20; a++) mem_s[a] = 9'(a);
        k = kfill(0);
        k[36 +: 9] = 9'd1;
        @(negedge clk);
        s_kernel = k; s_start = 1'b1; s_kc = 1'b0;
        saw_en = 0; saw_busy = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            saw_en   |= s_fmap_en;
            saw_busy |= s_busy;
        end
        checks++;
        if (saw_en || saw_busy) begin
            failures++;
            $display("FAIL start_without_kernel en_seen=%b busy_seen=%b required 0 0", saw_en, saw_busy);
        end
        @(negedge clk) s_kc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s_fmap_en !== 1'b1 || s_fmap_addr !== seq[i]) begin
                failures++;
                $display("FAIL fetch_addr[%0d] en=%b addr=%0d required en=1 addr=%0d", i, s_fmap_en, s_fmap_addr, seq[i]);
            end
        end
        wait_s(lat);
        checks++;
        if (s_done !== 1'b1) begin
            failures++;
            $display("FAIL center_done_timeout done=%b required 1", s_done);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_rd_addr = 13'(i);
            sb_s.push_back(23'((i / 3 + 1) * 5 + i % 3 + 1));
            @(posedge clk);
            #1 exp = sb_s.pop_front();
            checks++;
            if (s_rd_data !== exp) begin
                failures++;
                $display("FAIL center_result[%0d] got=%0d required=%0d", i, $signed(s_rd_data), $signed(exp));
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_done !== 1'b1 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL done_hold done=%b busy=%b required done=1 busy=0", s_done, s_busy);
        end
        @(negedge clk) s_start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s_done !== 1'b0) begin
            failures++;
            $display("FAIL done_release done=%b required 0", s_done);
        end
    endtask

    task automatic test_ones_kernel();
        logic [80:0] k;
        logic [22:0] exp;
        int lat;
        k = kfill(1);
        start_s(k);
        wait_s(lat);
        checks++;
        if (lat !== 79 || s_done !== 1'b1) begin
            failures++;
            $display("FAIL ones_latency got=%0d done=%b required 79", lat, s_done);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_rd_addr = 13'(i);
            sb_s.push_back(i == 0 ? 23'd54 : golden(0, i, k));
            @(posedge clk);
            #1 exp = sb_s.pop_front();
            checks++;
            if (s_rd_data !== exp) begin
                failures++;
                $display("FAIL ones_result[%0d] got=%0d required=%0d", i, $signed(s_rd_data), $signed(exp));
            end
        end
        release_s();
    endtask

    task automatic test_extremes();
        logic [22:0] exp;
        int lat;
        for (int a = 0; a < 20; a++) mem_s[a] = 9'h100;
        for (int pass = 0; pass < 2; pass++) begin
            start_s(pass == 0 ? kfill(-256) : kfill(255));
            wait_s(lat);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                s_rd_addr = 13'(i);
`ifdef STRIP_CONV_RELU_EN
                sb_s.push_back(pass == 0 ? 23'd589824 : 23'd0);
`else
                sb_s.push_back(pass == 0 ? 23'd589824 : 23'(-587520));
`endif
                @(posedge clk);
                #1 exp = sb_s.pop_front();
                checks++;
                if (s_rd_data !== exp) begin
                    failures++;
                    $display("FAIL extreme_p%0d[%0d] got=%0d required=%0d", pass, i, $signed(s_rd_data), $signed(exp));
                end
            end
            release_s();
        end
    endtask

    task automatic test_reset_mid_strip();
        logic [80:0] k;
        logic [22:0] exp;
        int lat;
        for (int a = 0; a < 20; a++) mem_s[a] = 9'($urandom_range(0, 511));
        k = krand();
        start_s(k);
        repeat (3 * 13 + 4) @(posedge clk);
        #3;
        checks++;
        if (s_busy !== 1'b1 || s_fmap_en !== 1'b1) begin
            failures++;
            $display("FAIL mid_strip_active busy=%b en=%b required 1 1", s_busy, s_fmap_en);
        end
        s_rst_n = 1'b0;
        #1;
        checks++;
        if ({s_busy, s_done, s_fmap_en} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset busy=%b done=%b en=%b required 0 0 0", s_busy, s_done, s_fmap_en);
        end
        @(negedge clk);
        s_start = 1'b0;
        s_rst_n = 1'b1;
        start_s(k);
        wait_s(lat);
        checks++;
        if (lat !== 79 || s_done !== 1'b1) begin
            failures++;
            $display("FAIL restart_latency got=%0d done=%b required 79", lat, s_done);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            s_rd_addr = 13'(i);
            sb_s.push_back(golden(0, i, k));
            @(posedge clk);
            #1 exp = sb_s.pop_front();
            checks++;
            if (s_rd_data !== exp) begin
                failures++;
                $display("FAIL restart_result[%0d] got=%0d required=%0d", i, $signed(s_rd_data), $signed(exp));
            end
        end
        release_s();
    endtask

    task automatic test_default_strip();
        logic [80:0] k;
        logic [22:0] exp;
        int idx [6];
        int lat;
        idx = '{0, 6215, 6216, 221, 3000, 8191};
        for (int a = 0; a < 6720; a++) mem_d[a] = 9'($urandom_range(0, 511));
        k = krand();
        d_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        d_rst_n = 1'b1;
        d_kernel = k; d_start = 1'b1; d_kc = 1'b1;
        @(posedge clk);
        #1 d_kernel = krand();
        lat = 0;
        while (lat < 90000 && d_done !== 1'b1) begin
            @(posedge clk);
            #1 lat++;
        end
        checks++;
        if (lat !== 6216 * 13 + 1 || d_done !== 1'b1) begin
            failures++;
            $display("FAIL default_latency got=%0d done=%b required %0d", lat, d_done, 6216 * 13 + 1);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d_rd_addr = 13'(idx[i]);
            sb_d.push_back(golden(1, idx[i], k));
            @(posedge clk);
            #1 exp = sb_d.pop_front();
            checks++;
            if (d_rd_data !== exp) begin
                failures++;
                $display("FAIL default_result[%0d] got=%0d required=%0d", idx[i], $signed(d_rd_data), $signed(exp));
            end
        end
        checks++;
        if (d_done !== 1'b1) begin
            failures++;
            $display("FAIL default_done_hold done=%b required 1", d_done);
        end
        @(negedge clk) d_start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (d_done !== 1'b0) begin
            failures++;
            $display("FAIL default_done_release done=%b required 0", d_done);
        end
    endtask

    initial begin
        s_rst_n = 1'b0; s_start = 1'b0; s_kc = 1'b0; s_kernel = '0; s_rd_addr = '0;
        d_rst_n = 1'b0; d_start = 1'b0; d_kc = 1'b0; d_kernel = '0; d_rd_addr = '0;
        fork
            begin
                test_reset();
                test_kernel_gate_center();
                test_ones_kernel();
                test_extremes();
                test_reset_mid_strip();
            end
            test_default_strip();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/strip_conv3x3_engine.md
Name: strip_conv3x3_engine

Overview:
- 3x3 signed convolution engine for one horizontal feature-map strip, using im2col-style patch gathering and a 9-lane multiply / adder-tree datapath.
- Reads the strip from an external synchronous-read memory port.
- Stores valid-mode results in an internal result RAM.
- After completion, exposes that RAM through a read-back port; one instance per strip in the segmented-frame convolution array.

Parameters:
- IMG_W, 224, strip width in pixels (row-major, fmap address = row*IMG_W+col).
- IMG_H, 30, strip height in rows.
- DW, 9, signed pixel and kernel coefficient width.
- OW, 23, signed result width.
- Derived, not overridable: OUT_W=IMG_W-2, OUT_H=IMG_H-2, N_OUT=OUT_W*OUT_H (6216 at defaults).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  level request to begin a strip.
- kernel_read_complete  in  1  kernel coefficients valid.
- kernel  in  9*DW  coefficients k0..k8; k0 at LSBs, row-major (k0=top-left, k8=bottom-right).
- fmap_en  out  1  fmap read enable.
- fmap_addr  out  16  fmap read address.
- fmap_data  in  DW  signed fmap read data, valid exactly 1 cycle after fmap_en.
- rd_addr  in  13  result read-back address.
- rd_data  out  OW  signed result at rd_addr, registered, 1-cycle latency.
- busy  out  1  high from leaving IDLE until DONE.
- done  out  1  strip complete.

Behaviour:
- Reset (reset=0, async): FSM=IDLE; busy, done, fmap_en = 0; fmap_addr=0; rd_data=0; row/col counters = 0; product registers = 0. Result RAM contents are not cleared.
- States: IDLE, FETCH, WAIT, MUL, ACC, NEXT, DONE.
- IDLE: when start && kernel_read_complete, latch kernel, clear r=c=0, go to FETCH. start alone does nothing.
- FETCH, 9 cycles, j=0..8: fmap_en=1, fmap_addr=(r+j/3)*IMG_W + c + j%3. Each fmap_data is captured one cycle later into patch[j-1], so the captures overlap FETCH cycles 1..8 plus WAIT.
- WAIT, 1 cycle: capture patch[8]; fmap_en=0.
- MUL, 1 cycle: p[j] = patch[j]*k[j]. Signed DWxDW -> 2*DW bits, registered.
- ACC, 1 cycle: sum of the 9 sign-extended products to OW bits, written to result RAM at index r*OUT_W+c.
- NEXT, 1 cycle: if c<OUT_W-1 then c+1; else c=0 and r+1. If r==OUT_H-1 && c==OUT_W-1, go to DONE; otherwise go to FETCH.
- Throughput: exactly 13 cycles per output pixel. done rises N_OUT*13+1 cycles after the IDLE exit edge.
- Arithmetic: no overflow possible. |sum| <= 9*65536 = 589824 < 2^22. Two's complement throughout; no saturation or rounding.
- DONE: done=1, busy=0. The FSM stays in DONE while start=1 and returns to IDLE when start=0. done clears on leaving DONE.
- Read-back: rd_data <= RAM[rd_addr] every cycle in any state. An out-of-range rd_addr (>=N_OUT) returns 0.
- Kernel changes after the IDLE exit have no effect until the next strip.
- Reset mid-strip aborts immediately. The next start restarts from r=c=0 and fully overwrites the results.

Optional Feature:
- Macro STRIP_CONV_RELU_EN.
- Defined: the ACC-stage value is clamped to 0 when negative before the RAM write.
- Undefined: the raw signed sum is stored.
- Timing is identical in both cases.

Test Plan:
- IMG_W=5, IMG_H=4; fmap[a]=a; kernel=center 1, others 0; start -> after done, rd_data at index r*3+c equals (r+1)*5+c+1. Index 0 -> 6; index 5 -> 13.
- Same image, all-ones kernel -> index 0 = 0+1+2+5+6+7+10+11+12 = 54; done asserts 6*13+1 = 79 cycles after the IDLE exit.
- All pixels -256, all coefficients -256 -> every result is +589824. With STRIP_CONV_RELU_EN and coefficients +255, every result is 0 (negative sum clamped).
- start=1 with kernel_read_complete=0 for 20 cycles -> fmap_en stays 0, busy=0. Assert kernel_read_complete -> FETCH on the next cycle; first fmap_addr=0, then 1, 2, IMG_W.
- Pulse reset low mid-strip (e.g. pixel 3) -> busy, done and fmap_en are 0 asynchronously. A restart produces full correct results.
- Default parameters, random data -> rd_addr 0 and 6215 match the golden model; rd_addr 6216 -> 0; done held while start=1 and cleared on start=0.
